// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between async_receiver and serial_ctrl, first-word-fall-through.
// Define UART_RX_FIFO_DROPCNT_EN to add the saturating dropped-byte counter dropCnt_o.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int INT_THRESHOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxdReady_i,
  input  logic [7:0]            rxdData_i,
  input  logic                  pop_i,
  input  logic                  clearOvf_i,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic                  int_o
`ifdef UART_RX_FIFO_DROPCNT_EN
  , output logic [15:0]         dropCnt_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] INT_THRESH = (DEPTH_LOG2 + 1)'(INT_THRESHOLD);

  logic [7:0]            mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  is_full;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  drop;

  // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
  always_comb begin
    is_full = (count == DEPTH_CNT);
    pop_ok  = pop_i && (count != '0);
    push_ok = rxdReady_i && (!is_full || pop_ok);
    drop    = rxdReady_i && is_full && !pop_ok;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= rxdData_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clearOvf_i) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROPCNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (clearOvf_i) begin
        drop_cnt <= 16'd1;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (clearOvf_i) begin
      drop_cnt <= '0;
    end
  end

  assign dropCnt_o = drop_cnt;
`endif

  always_comb begin
    valid_o    = (count != '0);
    full_o     = is_full;
    count_o    = count;
    overflow_o = overflow;
    int_o      = (count >= INT_THRESH);
    data_o     = valid_o ? mem[rd_ptr] : 8'h00;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, corner-case sequences, random vs queue model.
// Honours UART_RX_FIFO_DROPCNT_EN to also check dropCnt_o.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       rxdReady_i;
  logic [7:0] rxdData_i;
  logic       pop_i;
  logic       clearOvf_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       full_o;
  logic [4:0] count_o;
  logic       overflow_o;
  logic       int_o;
`ifdef UART_RX_FIFO_DROPCNT_EN
  logic [15:0] dropCnt_o;
`endif

  int tests;
  int failures;

  // Reference model: the FIFO contents as a plain queue of bytes.
  logic [7:0] m_q[$];
  logic       m_ovf;
  int         m_drop;

  uart_rx_fifo #(.DEPTH_LOG2(4), .INT_THRESHOLD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxdReady_i (rxdReady_i),
    .rxdData_i  (rxdData_i),
    .pop_i      (pop_i),
    .clearOvf_i (clearOvf_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .full_o     (full_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .int_o      (int_o)
`ifdef UART_RX_FIFO_DROPCNT_EN
    , .dropCnt_o (dropCnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic       clr;
    logic [4:0] ecount;
    logic [7:0] edata;
    logic       evalid;
    logic       efull;
    logic       eovf;
    logic       eint;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic applyStimulus(input logic push, input logic [7:0] din, input logic pop, input logic clr);
    bit pop_ok;
    bit drop;
    rxdReady_i = push;
    rxdData_i  = din;
    pop_i      = pop;
    clearOvf_i = clr;
    @(posedge clk);
    pop_ok = pop && (m_q.size() > 0);
    drop   = push && (m_q.size() == 16) && !pop_ok;
    if (pop_ok) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(din);
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    #1;
    rxdReady_i = 1'b0;
    rxdData_i  = 8'h00;
    pop_i      = 1'b0;
    clearOvf_i = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
    check({tag, ".count"}, 32'(count_o), 32'(m_q.size()));
    check({tag, ".valid"}, 32'(valid_o), 32'(m_q.size() > 0));
    check({tag, ".full"},  32'(full_o),  32'(m_q.size() == 16));
    check({tag, ".data"},  32'(data_o),  32'(exp_data));
    check({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
    check({tag, ".int"},   32'(int_o),   32'(m_q.size() >= 1));
`ifdef UART_RX_FIFO_DROPCNT_EN
    check({tag, ".dropcnt"}, 32'(dropCnt_o), 32'(m_drop));
`endif
  endtask

  initial begin
    tests      = 0;
    failures   = 0;
    rst        = 1'b1;
    rxdReady_i = 1'b0;
    rxdData_i  = 8'h00;
    pop_i      = 1'b0;
    clearOvf_i = 1'b0;
    modelReset();

    //            push din    pop clr  cnt    data   v  f  o  i
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h55, 1'b1, 1'b0, 5'd1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'h22, 1'b0, 1'b1, 5'd2, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h33, 1'b1, 1'b0, 5'd2, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", 32'(valid_o), 32'd0);
    check("reset.data",  32'(data_o),  32'h00);
    check("reset.count", 32'(count_o), 32'd0);
    check("reset.ovf",   32'(overflow_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].clr);
      check($sformatf("vec%0d.count", i), 32'(count_o),    32'(vecs[i].ecount));
      check($sformatf("vec%0d.data", i),  32'(data_o),     32'(vecs[i].edata));
      check($sformatf("vec%0d.valid", i), 32'(valid_o),    32'(vecs[i].evalid));
      check($sformatf("vec%0d.full", i),  32'(full_o),     32'(vecs[i].efull));
      check($sformatf("vec%0d.ovf", i),   32'(overflow_o), 32'(vecs[i].eovf));
      check($sformatf("vec%0d.int", i),   32'(int_o),      32'(vecs[i].eint));
    end

    // Fill to 16, then one dropped byte.
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full",  32'(full_o),     32'd1);
    check("fill.count", 32'(count_o),    32'd16);
    check("fill.ovf",   32'(overflow_o), 32'd1);
    check("fill.data",  32'(data_o),     32'h00);

    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    check("fullpush.count", 32'(count_o),    32'd16);
    check("fullpush.ovf",   32'(overflow_o), 32'd1);
    check("fullpush.data",  32'(data_o),     32'h01);

    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    check("clrdrop.ovf",   32'(overflow_o), 32'd1);
    check("clrdrop.count", 32'(count_o),    32'd16);
`ifdef UART_RX_FIFO_DROPCNT_EN
    check("clrdrop.dropcnt", 32'(dropCnt_o), 32'd1);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr.ovf", 32'(overflow_o), 32'd0);
`ifdef UART_RX_FIFO_DROPCNT_EN
    check("clr.dropcnt", 32'(dropCnt_o), 32'd0);
`endif

    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d.data", i), 32'(data_o), (i < 15) ? 32'(i + 1) : 32'hAA);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain.count", 32'(count_o), 32'd0);
    check("drain.valid", 32'(valid_o), 32'd0);

    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("drop20.count", 32'(count_o),    32'd16);
    check("drop20.ovf",   32'(overflow_o), 32'd1);
`ifdef UART_RX_FIFO_DROPCNT_EN
    check("drop20.dropcnt", 32'(dropCnt_o), 32'd4);
`endif

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    check("asyncrst.count", 32'(count_o),    32'd0);
    check("asyncrst.valid", 32'(valid_o),    32'd0);
    check("asyncrst.data",  32'(data_o),     32'h00);
    check("asyncrst.full",  32'(full_o),     32'd0);
    check("asyncrst.ovf",   32'(overflow_o), 32'd0);
    check("asyncrst.int",   32'(int_o),      32'd0);
    modelReset();
    #2 rst = 1'b0;
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("postrst");

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 5);
      checkOutput("rndA");
    end
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 99) < 70,
                    $urandom_range(0, 99) < 5);
      checkOutput("rndB");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
